// File: rtl/multi_zone_light_ctrl.sv
// multi_zone_light_ctrl: per-zone occupancy lights with hold timers, manual override and a shared hysteretic dark flag
module multi_zone_light_ctrl #(
    parameter int NUM_ZONES   = 4,
    parameter int LUM_W       = 8,
    parameter int LUM_ON_TH   = 32,
    parameter int LUM_OFF_TH  = 64,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LUM_W-1:0]               lum_sen,
    input  logic [NUM_ZONES-1:0]           motion_sen,
    input  logic [NUM_ZONES-1:0]           ir_sen,
    input  logic [NUM_ZONES-1:0]           manual,
    input  logic [NUM_ZONES-1:0]           man_val,
    output logic [NUM_ZONES-1:0]           int_light,
    output logic                           dark,
    output logic [$clog2(NUM_ZONES+1)-1:0] lights_on
);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(NUM_ZONES + 1);
    localparam logic [LUM_W-1:0] ON_TH     = LUM_W'(LUM_ON_TH);
    localparam logic [LUM_W-1:0] OFF_TH    = LUM_W'(LUM_OFF_TH);
    localparam logic [TW-1:0]    HOLD_INIT = TW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {OFF, ON, HOLD} state_t;

    state_t               st [NUM_ZONES];
    state_t               st_n [NUM_ZONES];
    logic [TW-1:0]        tmr [NUM_ZONES];
    logic [TW-1:0]        tmr_n [NUM_ZONES];
    logic [NUM_ZONES-1:0] occ;
    logic [NUM_ZONES-1:0] light_n;
    logic                 dark_n;

    assign occ    = motion_sen | ir_sen;
    assign dark_n = (lum_sen < ON_TH) ? 1'b1 : (lum_sen > OFF_TH) ? 1'b0 : dark;

    always_ff @(posedge clk) begin
        if (reset) begin
            dark      <= 1'b0;
            int_light <= '0;
            for (int i = 0; i < NUM_ZONES; i++) begin
                st[i]  <= OFF;
                tmr[i] <= '0;
            end
        end else begin
            dark      <= dark_n;
            int_light <= light_n;
            for (int i = 0; i < NUM_ZONES; i++) begin
                st[i]  <= st_n[i];
                tmr[i] <= tmr_n[i];
            end
        end
    end

    // zones act on the registered dark flag, giving two edges from lum to light
    always_comb begin
        for (int i = 0; i < NUM_ZONES; i++) begin
            st_n[i]  = st[i];
            tmr_n[i] = tmr[i];
            if (manual[i] || !dark) begin
                st_n[i]  = OFF;
                tmr_n[i] = '0;
            end else if (st[i] == OFF) begin
                st_n[i] = occ[i] ? ON : OFF;
            end else if (st[i] == ON) begin
                if (!occ[i]) begin
                    st_n[i]  = HOLD;
                    tmr_n[i] = HOLD_INIT;
                end
            end else if (occ[i]) begin
                st_n[i] = ON;
            end else if (tmr[i] == '0) begin
                st_n[i] = OFF;
            end else begin
                tmr_n[i] = tmr[i] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ZONES; i++)
            light_n[i] = manual[i] ? man_val[i] : (st_n[i] != OFF);
    end

    always_comb begin
        lights_on = '0;
        for (int i = 0; i < NUM_ZONES; i++)
            lights_on = lights_on + LW'(int_light[i]);
    end
endmodule

// File: tb/tb_multi_zone_light_ctrl.sv
// tb_multi_zone_light_ctrl: directed scenarios plus random traffic against a remaining-on-time reference model
module tb_multi_zone_light_ctrl;
    localparam int NZ = 4, HOLD = 8, ON_TH = 32, OFF_TH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    lum_sen = '0;
    logic [NZ-1:0] motion_sen = '0, ir_sen = '0, manual = '0, man_val = '0;
    logic [NZ-1:0] int_light;
    logic          dark;
    logic [2:0]    lights_on;

    int checks = 0, errors = 0;
    bit          m_dark;
    bit [NZ-1:0] m_light;
    int          m_rem [NZ];

    always #5 clk = ~clk;

    multi_zone_light_ctrl dut (
        .clk(clk), .reset(reset), .lum_sen(lum_sen), .motion_sen(motion_sen), .ir_sen(ir_sen),
        .manual(manual), .man_val(man_val), .int_light(int_light), .dark(dark), .lights_on(lights_on)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // model: each zone keeps the number of edges its light may still stay on without presence
    task automatic step(input string tag);
        @(posedge clk);
        if (reset) begin
            m_dark  = 1'b0;
            m_light = '0;
            for (int i = 0; i < NZ; i++) m_rem[i] = 0;
        end else begin
            for (int i = 0; i < NZ; i++) begin
                if (manual[i] || !m_dark) begin
                    m_rem[i]   = 0;
                    m_light[i] = manual[i] & man_val[i];
                end else if (motion_sen[i] || ir_sen[i]) begin
                    m_rem[i]   = HOLD;
                    m_light[i] = 1'b1;
                end else begin
                    m_light[i] = m_rem[i] > 0;
                    if (m_rem[i] > 0) m_rem[i]--;
                end
            end
            if (int'(lum_sen) < ON_TH) m_dark = 1'b1;
            else if (int'(lum_sen) > OFF_TH) m_dark = 1'b0;
        end
        #1;
        check({tag, " light"}, 32'(int_light), 32'(m_light));
        check({tag, " dark"}, 32'(dark), 32'(m_dark));
        check({tag, " count"}, 32'(lights_on), 32'($countones(m_light)));
    endtask

    task automatic count_hold(input string tag);
        int n = 0;
        for (int k = 0; k < 20; k++) begin
            step(tag);
            if (!int_light[0]) break;
            n++;
        end
        check({tag, " on_edges"}, 32'(n), 32'(HOLD));
    endtask

    initial begin
        motion_sen = '1; ir_sen = '1; manual = '1; man_val = '1;
        repeat (3) step("reset");
        check("reset light", 32'(int_light), 32'h0);
        check("reset dark", 32'(dark), 32'h0);
        reset = 1'b0; motion_sen = '0; ir_sen = '0; manual = '0; man_val = '0; lum_sen = 8'd8;
        repeat (2) step("dark_up");
        check("dark set", 32'(dark), 32'h1);
        motion_sen = 4'b0001;
        step("zone0_on");
        check("zone0 on", 32'(int_light), 32'h1);
        check("zone0 count", 32'(lights_on), 32'h1);
        motion_sen = '0;
        count_hold("hold");
        motion_sen = 4'b0001; step("reon");
        motion_sen = '0; repeat (4) step("hold_part");
        motion_sen = 4'b0001; step("pulse");
        check("pulse no gap", 32'(int_light[0]), 32'h1);
        motion_sen = '0;
        count_hold("rehold");
        motion_sen = '1; repeat (2) step("all_occ");
        lum_sen = 8'd32; repeat (2) step("lum32");
        lum_sen = 8'd64; repeat (2) step("lum64");
        check("lum64 dark", 32'(dark), 32'h1);
        check("lum64 light", 32'(int_light), 32'hf);
        lum_sen = 8'd65; step("lum65a");
        check("lum65 dark", 32'(dark), 32'h0);
        check("lum65 light", 32'(int_light), 32'hf);
        step("lum65b");
        check("lum65 off", 32'(int_light), 32'h0);
        lum_sen = 8'd40; repeat (2) step("lum40");
        check("lum40 dark", 32'(dark), 32'h0);
        motion_sen = '0; lum_sen = 8'd128; manual = 4'b0010; man_val = 4'b0010;
        step("man_on");
        check("man on", 32'(int_light), 32'h2);
        man_val = '0; step("man_off");
        check("man off", 32'(int_light), 32'h0);
        lum_sen = 8'd8; ir_sen = 4'b0010; repeat (2) step("man_dark");
        manual = '0; step("man_rel");
        check("release on", 32'(int_light), 32'h2);
        ir_sen = '0; motion_sen = 4'b0011; step("mix_a");
        motion_sen = 4'b0001; manual = 4'b1000; man_val = 4'b1000; repeat (3) step("mix_b");
        check("mix light", 32'(int_light), 32'h b);
        reset = 1'b1; step("mix_rst");
        check("mix reset", 32'(int_light), 32'h0);
        reset = 1'b0; manual = '0; repeat (3) step("resume");
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 59) == 0);
            lum_sen    = 8'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(28, 68));
            motion_sen = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            ir_sen     = 4'($urandom_range(0, 5) == 0 ? $urandom : 0);
            manual     = 4'($urandom_range(0, 7) == 0 ? $urandom : 0);
            man_val    = 4'($urandom);
            step("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
